// File: rtl/pe_conv_mac_cell_if.sv
// pe_conv_mac_cell_if: activation-in / result-out stream bundle for the conv MAC cell
//   in_valid/in_ready/input_act/vf_store : activation beat stream (producer -> cell)
//   out_valid/out_ready/psum_out/sat_flag : saturated result stream (cell -> consumer)
//   master = producer/consumer side, slave = cell side
interface pe_conv_mac_cell_if #(
  parameter int BW_ACT = 8,
  parameter int LANES  = 4,
  parameter int BW_OUT = 17
);
  logic                      in_valid;
  logic                      in_ready;
  logic [LANES*BW_ACT-1:0]   input_act;
  logic                      vf_store;
  logic                      out_valid;
  logic                      out_ready;
  logic signed [BW_OUT-1:0]  psum_out;
  logic                      sat_flag;
  modport master (
    output in_valid, input_act, vf_store, out_ready,
    input  in_ready, out_valid, psum_out, sat_flag
  );
  modport slave (
    input  in_valid, input_act, vf_store, out_ready,
    output in_ready, out_valid, psum_out, sat_flag
  );
endinterface

// File: rtl/pe_conv_mac_cell.sv
// pe_conv_mac_cell: multi-lane output-stationary MAC cell with H/V forwarding and saturated result port
//   clk, rst_n (async, active-low), clr (sync abort)
//   cfg_acc_len : beats per result minus 1, sampled on the first beat
//   load_weight/input_weight : weight vector load, honoured only when idle and drained
//   H_buffer/V_buffer : last accepted beat / last accepted beat with vf_store
//   bus : activation in-stream and result out-stream (slave side)
module pe_conv_mac_cell #(
  parameter int BW_ACT = 8,
  parameter int BW_WT  = 8,
  parameter int LANES  = 4,
  parameter int BW_ACC = 32,
  parameter int BW_OUT = 17,
  parameter int BW_LEN = 8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    clr,
  input  logic [BW_LEN-1:0]       cfg_acc_len,
  input  logic                    load_weight,
  input  logic [LANES*BW_WT-1:0]  input_weight,
  output logic [LANES*BW_ACT-1:0] H_buffer,
  output logic [LANES*BW_ACT-1:0] V_buffer,
  pe_conv_mac_cell_if.slave       bus
);
  typedef enum logic [1:0] {IDLE, ACC, WAIT} state_t;
  localparam logic signed [BW_ACC-1:0] HI = {{(BW_ACC-BW_OUT+1){1'b0}}, {(BW_OUT-1){1'b1}}};
  localparam logic signed [BW_ACC-1:0] LO = ~HI;
  state_t                   state;
  logic [BW_LEN:0]          cnt;
  logic [BW_LEN-1:0]        len_reg;
  logic [LANES*BW_ACT-1:0]  act_reg;
  logic [LANES*BW_WT-1:0]   weight_buffer;
  logic                     s1_valid, s1_first, s1_last;
  logic signed [BW_ACC-1:0] acc, dot, acc_next;
  logic                     accept, over, under;
  assign bus.in_ready = state != WAIT;
  assign accept       = bus.in_valid && bus.in_ready;
  always_comb begin
    dot = '0;
    for (int i = 0; i < LANES; i++)
      dot = dot + BW_ACC'($signed(act_reg[i*BW_ACT +: BW_ACT]) * $signed(weight_buffer[i*BW_WT +: BW_WT]));
    acc_next = (s1_first ? '0 : acc) + dot;
    over     = acc_next > HI;
    under    = acc_next < LO;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      cnt           <= '0;
      len_reg       <= '0;
      act_reg       <= '0;
      weight_buffer <= '0;
      s1_valid      <= 1'b0;
      s1_first      <= 1'b0;
      s1_last       <= 1'b0;
      acc           <= '0;
      H_buffer      <= '0;
      V_buffer      <= '0;
      bus.out_valid <= 1'b0;
      bus.psum_out  <= '0;
      bus.sat_flag  <= 1'b0;
    end else if (clr) begin
      state         <= IDLE;
      cnt           <= '0;
      s1_valid      <= 1'b0;
      acc           <= '0;
      bus.out_valid <= 1'b0;
      bus.sat_flag  <= 1'b0;
    end else begin
      s1_valid <= accept;
      if (accept) begin
        act_reg  <= bus.input_act;
        H_buffer <= bus.input_act;
        if (bus.vf_store) V_buffer <= bus.input_act;
        s1_first <= state == IDLE;
        if (state == IDLE) begin
          len_reg <= cfg_acc_len;
          cnt     <= 1;
          s1_last <= cfg_acc_len == '0;
          state   <= cfg_acc_len == '0 ? WAIT : ACC;
        end else begin
          // cnt counts beats already taken, so this beat is the last when cnt == len_reg
          cnt     <= cnt + 1'b1;
          s1_last <= cnt == {1'b0, len_reg};
          if (cnt == {1'b0, len_reg}) state <= WAIT;
        end
      end
      if (load_weight && state == IDLE && !s1_valid) weight_buffer <= input_weight;
      if (s1_valid) begin
        acc <= acc_next;
        if (s1_last) begin
          bus.psum_out  <= over ? HI[BW_OUT-1:0] : under ? LO[BW_OUT-1:0] : acc_next[BW_OUT-1:0];
          bus.sat_flag  <= over || under;
          bus.out_valid <= 1'b1;
        end
      end
      if (bus.out_valid && bus.out_ready) begin
        bus.out_valid <= 1'b0;
        state         <= IDLE;
      end
    end
  end
endmodule

// File: doc/pe_conv_mac_cell.md
# pe_conv_mac_cell

Multi-lane, output-stationary successor to the single-lane conv PE. Each accepted activation beat carries LANES signed activations, which are multiplied by LANES stored signed weights and summed. The sum accumulates over a programmable number of beats, and the saturated result is emitted on a valid/ready port. H/V forwarding buffers for the systolic array are kept, with the same semantics, widened to LANES.

## Interface
- BW_ACT, 8, bits per activation lane (signed)
- BW_WT, 8, bits per weight lane (signed)
- LANES, 4, activation/weight lanes per beat (>=1)
- BW_ACC, 32, internal signed accumulator width
- BW_OUT, 17, signed output width (BW_OUT <= BW_ACC)
- BW_LEN, 8, width of beat-count config
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- clr  in  1  synchronous abort: flush pipeline, accumulator, counter, pending output
- cfg_acc_len  in  BW_LEN  beats per result minus 1; sampled on first beat of a result
- load_weight  in  1  load weight vector (honoured only in IDLE with no beat in flight)
- input_weight  in  LANES*BW_WT  lane i at [i*BW_WT +: BW_WT]
- in_valid  in  1  activation beat valid
- in_ready  out  1  beat accepted when in_valid && in_ready
- input_act  in  LANES*BW_ACT  lane i at [i*BW_ACT +: BW_ACT]
- vf_store  in  1  also capture beat into V_buffer
- H_buffer  out  LANES*BW_ACT  last accepted beat (horizontal forward)
- V_buffer  out  LANES*BW_ACT  last accepted beat with vf_store=1 (vertical forward)
- out_valid  out  1  result valid, held until out_ready
- out_ready  in  1  consumer ready
- psum_out  out  BW_OUT  saturated signed result
- sat_flag  out  1  psum_out was clipped; qualified by out_valid

## Operation
- States: IDLE (no beat of the current result accepted), ACC (1..len beats accepted), WAIT (last beat accepted; draining and/or holding the result).
- in_ready = 1 in IDLE/ACC, 0 in WAIT. Nothing else gates it.
- Accept in IDLE: len_reg <= cfg_acc_len, cnt <= 1, act_reg <= input_act, first tag set. Go to ACC, or to WAIT if cfg_acc_len == 0.
- Accept in ACC: act_reg <= input_act, cnt++. Go to WAIT when the accepted beat is beat len_reg+1.
- Stage 2 (cycle after act_reg loads): dot = sum over lanes of $signed(act_i)*$signed(wt_i), sign-extended to BW_ACC. acc <= (first ? 0 : acc) + dot. Acc wraps modulo 2^BW_ACC; no internal saturation.
- When the stage-2 beat is last: psum_out <= clamp(acc_next) to [-2^(BW_OUT-1), 2^(BW_OUT-1)-1]. sat_flag <= clipped. out_valid <= 1.
- WAIT -> IDLE on out_valid && out_ready. out_valid drops the following cycle.
- Weights: on load_weight in IDLE with no stage-2 beat pending, weight_buffer <= input_weight next edge. Ignored otherwise, so weights are constant across a result.
- H/V: on accept, H_buffer <= input_act. V_buffer <= input_act iff vf_store. Otherwise both hold.
- clr: next edge state=IDLE, cnt=0, act_reg valid=0, acc=0, out_valid=0, sat_flag=0. Weights, H/V buffers and psum_out data hold. clr wins over a simultaneous accept (beat discarded, H/V not updated) and over an output handshake.

## Timing
- Reset values: in_ready=1 (state IDLE), out_valid=0, psum_out=0, sat_flag=0, H_buffer=0, V_buffer=0. Also weight_buffer=0, acc=0, cnt=0.
- Reset asserted mid-result: everything returns to reset values asynchronously; the partial result is lost.
- Latency: last beat accepted at edge E0 -> stage 2 at E1 -> out_valid high after E1. That is 2 cycles from the last handshake cycle to out_valid.
- Throughput: one beat per cycle within a result. The minimum gap between results is 2 cycles of in_ready=0 with out_ready held 1.
- out_valid/psum_out/sat_flag are stable while out_valid && !out_ready.
- in_valid may be deasserted between beats without limit. The accumulator holds.

## Test plan
- LANES=4, weights [1,1,1,1], cfg_acc_len=2, beats [1,2,3,4]×3 back-to-back -> one result psum_out=30, sat_flag=0, out_valid 2 cycles after the third accept.
- Weights [-128]×4, single beat (cfg_acc_len=0) acts [-128]×4 -> dot=65536 -> psum_out=65535, sat_flag=1. Same with acts [127]×4 -> -65024, sat_flag=0.
- out_ready=0 for 5 cycles after out_valid -> psum_out stable, in_ready=0 throughout. Next result's first beat accepted the cycle after the handshake.
- clr asserted together with the 2nd of 3 beats -> no out_valid. The next 1-beat result equals that beat's dot alone, with no residue.
- load_weight pulsed mid-result -> ignored, result uses old weights. The same pulse in IDLE takes effect for the next beat.
- vf_store alternating 1,0 over beats A,B -> H_buffer=B, V_buffer=A. Async rst_n mid-result -> all outputs 0, in_ready=1.
